// File: rtl/led_scan_pkg.sv
// -----------------------------------------------------------------------------
// led_scan_pkg
// Shared constants and the sequence-step helper for the LED scan select
// generator.
//   - MODE_*  : encoding of the 2-bit mode input
//   - DIR_*   : ping-pong travel direction encoding
//   - seq_next: next select value, direction and wrap flag for one advance
// -----------------------------------------------------------------------------
package led_scan_pkg;

    // Mode input encoding
    localparam logic [1:0] MODE_UP       = 2'b00;
    localparam logic [1:0] MODE_DOWN     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    // Travel direction (the only state of the ping-pong state machine)
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Ends of the 3-bit select range
    localparam logic [2:0] SEL_MIN = 3'd0;
    localparam logic [2:0] SEL_MAX = 3'd7;

    // Result of one advance of the sequence
    typedef struct packed {
        logic [2:0] sel;
        logic       dir;
        logic       wrap;
    } seq_next_t;

    // Computes the state after one advance. The returned dir already reflects
    // the direction tracking done in up/down modes; hold keeps everything.
    function automatic seq_next_t seq_next(
        input logic [1:0] mode,
        input logic [2:0] sel,
        input logic       dir
    );
        seq_next_t r;
        r.sel  = sel;
        r.dir  = dir;
        r.wrap = 1'b0;
        case (mode)
            MODE_UP: begin
                r.sel  = sel + 3'd1;
                r.dir  = DIR_UP;
                r.wrap = (sel == SEL_MAX);
            end
            MODE_DOWN: begin
                r.sel  = sel - 3'd1;
                r.dir  = DIR_DOWN;
                r.wrap = (sel == SEL_MIN);
            end
            MODE_PINGPONG: begin
                // Turn around at the ends without repeating the end value
                if (dir == DIR_UP) begin
                    if (sel == SEL_MAX) begin
                        r.sel  = SEL_MAX - 3'd1;
                        r.dir  = DIR_DOWN;
                        r.wrap = 1'b1;
                    end else begin
                        r.sel  = sel + 3'd1;
                        r.dir  = DIR_UP;
                        r.wrap = 1'b0;
                    end
                end else begin
                    if (sel == SEL_MIN) begin
                        r.sel  = SEL_MIN + 3'd1;
                        r.dir  = DIR_UP;
                        r.wrap = 1'b1;
                    end else begin
                        r.sel  = sel - 3'd1;
                        r.dir  = DIR_DOWN;
                        r.wrap = 1'b0;
                    end
                end
            end
            MODE_HOLD: begin
                r.sel  = sel;
                r.dir  = dir;
                r.wrap = 1'b0;
            end
            default: begin
                r.sel  = sel;
                r.dir  = dir;
                r.wrap = 1'b0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led_scan_seq_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running prescaler with synchronous clear. pulse is high while the
// counter sits on its last value (DIV-1); the counter then returns to 0.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset, counter to 0
//   clr   : synchronous clear, holds the counter at 0
//   pulse : high during the last cycle of each DIV-cycle period
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic pulse
);
    localparam int             CW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          last_s;

    // Terminal-count decode from the registered counter only
    always_comb begin
        last_s = (cnt_r == CNT_LAST);
    end

    // Prescaler counter: cleared, wrapped at DIV-1, or incremented
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (last_s) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign pulse = last_s;

endmodule

// File: rtl/led_scan_seq.sv
// -----------------------------------------------------------------------------
// led_scan_seq
// 3-bit select sequence generator feeding a 3-to-8 decoder. Steps the select
// {a,b,c} up, down, ping-pong or holds it, either every TICK_DIV clocks
// (en=1) or on each rising edge of step (en=0).
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   en   : 1 = free-run on prescaler, 0 = manual step only
//   mode : 00 up, 01 down, 10 ping-pong, 11 hold
//   step : manual step request (rising edge used), only while en=0
//   a,b,c: registered select, a is the MSB
//   tick : one-cycle strobe in the cycle a new select first appears
//   wrap : one-cycle strobe on wrap (up/down) or turnaround (ping-pong)
// -----------------------------------------------------------------------------
module led_scan_seq
    import led_scan_pkg::*;
#(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       step,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       tick,
    output logic       wrap
);

    logic        pulse_s;
    logic        step_q_r;
    logic        step_rise_s;
    logic        adv_s;
    logic [2:0]  sel_r;
    logic        dir_r;
    logic        tick_r;
    logic        wrap_r;
    seq_next_t   seq_nxt_s;
    logic        dir_nxt_s;

    // Prescaler is held cleared while stepping manually, so re-enabling
    // always gives a full period before the first automatic step.
    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clr   (~en),
        .pulse (pulse_s)
    );

    // Step input delay register for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q_r <= 1'b0;
        end else begin
            step_q_r <= step;
        end
    end

    // Advance request: prescaler when free-running, step edge otherwise.
    // Uses the current en, so en dropping on the terminal count advances
    // nothing and a step edge coinciding with en=1 is ignored.
    always_comb begin
        step_rise_s = step & ~step_q_r;
        adv_s       = (en & pulse_s) | (~en & step_rise_s);
    end

    // Next sequence state; dir follows mode every cycle outside ping-pong,
    // but inside ping-pong it only changes at a turnaround advance.
    always_comb begin
        seq_nxt_s = seq_next(mode, sel_r, dir_r);
        if ((mode == MODE_PINGPONG) && !adv_s) begin
            dir_nxt_s = dir_r;
        end else begin
            dir_nxt_s = seq_nxt_s.dir;
        end
    end

    // Select, direction and strobe registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_r  <= SEL_MIN;
            dir_r  <= DIR_UP;
            tick_r <= 1'b0;
            wrap_r <= 1'b0;
        end else begin
            dir_r  <= dir_nxt_s;
            tick_r <= adv_s;
            wrap_r <= adv_s & seq_nxt_s.wrap;
            if (adv_s) begin
                sel_r <= seq_nxt_s.sel;
            end else begin
                sel_r <= sel_r;
            end
        end
    end

    assign a    = sel_r[2];
    assign b    = sel_r[1];
    assign c    = sel_r[0];
    assign tick = tick_r;
    assign wrap = wrap_r;

endmodule

// File: tb/tb_led_scan_seq.sv
// -----------------------------------------------------------------------------
// tb_led_scan_seq
// Directed and randomized stimulus for led_scan_seq with TICK_DIV=4, checked
// against a behavioural model that tracks position, travel direction and the
// number of enabled cycles with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_led_scan_seq;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       step;
    logic       a, b, c, tick, wrap;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int m_sel;       // current position 0..7
    bit m_down;      // travelling downwards
    int m_run;       // consecutive enabled cycles since en last low/reset
    bit m_prev_step; // step value seen at the previous edge
    bit m_tick, m_wrap;

    led_scan_seq #(.TICK_DIV(TICK_DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .step (step),
        .a    (a),
        .b    (b),
        .c    (c),
        .tick (tick),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_sel = 0; m_down = 1'b0; m_run = 0; m_prev_step = 1'b0;
        m_tick = 1'b0; m_wrap = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using the current inputs
    task automatic model_edge();
        bit adv;
        bit w;
        int n;
        adv = 1'b0;
        w   = 1'b0;
        n   = m_sel;
        if (en) begin
            m_run = m_run + 1;
            adv   = (m_run % TICK_DIV) == 0;
        end else begin
            m_run = 0;
            adv   = step && !m_prev_step;
        end
        if (adv) begin
            if (mode == 2'b00) begin
                n = (m_sel + 1) % 8;
                w = (m_sel == 7);
            end else if (mode == 2'b01) begin
                n = (m_sel + 7) % 8;
                w = (m_sel == 0);
            end else if (mode == 2'b10) begin
                n = m_down ? m_sel - 1 : m_sel + 1;
                if (n > 7) begin n = 6; w = 1'b1; m_down = 1'b1; end
                if (n < 0) begin n = 1; w = 1'b1; m_down = 1'b0; end
            end
        end
        if (mode == 2'b00) m_down = 1'b0;
        if (mode == 2'b01) m_down = 1'b1;
        m_sel       = n;
        m_tick      = adv;
        m_wrap      = adv && w;
        m_prev_step = step;
    endtask

    task automatic check(input string tag);
        logic [4:0] obs;
        logic [4:0] exp;
        obs = {a, b, c, tick, wrap};
        exp = {3'(m_sel), m_tick, m_wrap};
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed {a,b,c,tick,wrap}=%b expected %b", tag, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock: model, edge, then sample on the falling edge
    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check(tag);
    endtask

    // Asynchronous reset asserted between clock edges, checked before any edge
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        int ticks;
        rst = 1'b1; en = 1'b0; mode = 2'b00; step = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset_state");
        rst = 1'b0;

        // Up mode free-run
        en = 1'b1; mode = 2'b00;
        for (int i = 0; i < 40; i++) cycle("up_run");

        // Run to sel=5, then reset mid-run
        cnt = 0;
        while (m_sel != 5 && cnt < 40) begin cycle("up_to5"); cnt++; end
        check_int("reach_sel5", m_sel, 5);
        async_reset("rst_midrun");
        cnt = 0;
        while (!tick && cnt < 10) begin cycle("post_rst"); cnt++; end
        check_int("post_rst_latency", cnt, TICK_DIV);
        check_int("post_rst_sel", {29'd0, a, b, c}, 1);

        // Down mode from reset
        async_reset("rst_down");
        mode = 2'b01;
        for (int i = 0; i < 40; i++) cycle("down_run");

        // Ping-pong from reset
        async_reset("rst_pp");
        mode = 2'b10;
        for (int i = 0; i < 70; i++) cycle("pp_run");

        // Manual stepping: level held, then two single-cycle pulses
        async_reset("rst_manual");
        en = 1'b0; mode = 2'b00;
        ticks = 0;
        step = 1'b1;
        for (int i = 0; i < 10; i++) begin cycle("man_level"); ticks += int'(tick); end
        step = 1'b0;
        for (int i = 0; i < 3; i++) begin cycle("man_low"); ticks += int'(tick); end
        for (int p = 0; p < 2; p++) begin
            step = 1'b1; cycle("man_pulse"); ticks += int'(tick);
            step = 1'b0;
            for (int i = 0; i < 3; i++) begin cycle("man_gap"); ticks += int'(tick); end
        end
        check_int("man_advances", ticks, 3);
        check_int("man_sel", {29'd0, a, b, c}, 3);

        // Step while free-running causes no extra advance
        en = 1'b1;
        step = 1'b1; cycle("en_step");
        step = 1'b0;
        for (int i = 0; i < 12; i++) cycle("en_step_run");

        // Hold mode, then en 1->0->1 mid-count
        mode = 2'b11;
        for (int i = 0; i < 14; i++) cycle("hold_run");
        en = 1'b0;
        for (int i = 0; i < 3; i++) cycle("hold_off");
        en = 1'b1;
        cnt = 0;
        cycle("reen"); cnt++;
        while (!tick && cnt < 10) begin cycle("reen"); cnt++; end
        check_int("reen_latency", cnt, TICK_DIV);

        // Randomized mixed stimulus
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) en = ~en;
            step = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
            else cycle("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_scan_seq.md
Name: led_scan_seq

Overview:
- Select-sequence generator directly upstream of the 3-to-8 decoder.
- Produces the 3-bit select {a,b,c}, where a is the MSB, and steps it at a programmable rate. The decoder's one-hot output then forms a running-light or scan pattern.
- Supports up, down, ping-pong and hold modes, plus single-step when the free-run is disabled.
- Emits tick and wrap strobes for downstream logic.

Parameters:
- TICK_DIV, 12_500_000, clock cycles per automatic step (250 ms at 50 MHz). Legal range ≥ 2. Counter width is $clog2(TICK_DIV).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  1 = free-run stepping on prescaler; 0 = prescaler cleared, manual step only.
- mode  input  2  00 up, 01 down, 10 ping-pong, 11 hold.
- step  input  1  manual step request, level or pulse; rising edge detected internally; honoured only when en=0.
- a  output  1  select bit 2 (MSB) to decoder.
- b  output  1  select bit 1.
- c  output  1  select bit 0.
- tick  output  1  one-cycle strobe, high in the cycle the new select value first appears.
- wrap  output  1  one-cycle strobe when the sequence wraps (up 7→0, down 0→7) or turns around (ping-pong at 7 or 0).

Behaviour:
- Reset (async, immediate, any time including mid-step):
  - sel={a,b,c}=3'b000, tick=0, wrap=0, cnt=0, dir=UP, step_q=0.
  - First update possible on the first rising clk edge after rst deasserts.
- Prescaler:
  - en=1: cnt increments each cycle; cnt==TICK_DIV-1 gives adv=1 and cnt←0.
  - en=0: cnt held at 0, so re-enabling yields a full TICK_DIV period before the first step.
- Step detect:
  - step_q registers step.
  - step_rise = step & ~step_q.
  - adv = (en & cnt==TICK_DIV-1) | (~en & step_rise). A step while en=1 is ignored.
- Advance: on the edge where adv=1, sel updates and tick←1 for exactly one cycle. All outputs are registered with no combinational path from input to output. Manual-step latency is 1 cycle from the rising edge of step.
- Mode up: sel←sel+1 mod 8; wrap←1 when old sel=7.
- Mode down: sel←sel-1 mod 8; wrap←1 when old sel=0.
- Mode ping-pong, dir state machine:
  - UP: sel=7 → sel←6, dir←DOWN, wrap←1; else sel←sel+1.
  - DOWN: sel=0 → sel←1, dir←UP, wrap←1; else sel←sel-1.
- Mode hold: sel unchanged, tick still pulses on adv, wrap=0.
- dir outside ping-pong: dir tracks mode every cycle (up→UP, down→DOWN, hold→unchanged). Entering ping-pong therefore continues in the last travel direction.
- Mode change: sampled at each adv and takes effect on that advance. No restart of the prescaler.
- Simultaneous events:
  - en falling while cnt==TICK_DIV-1: adv uses the current en, so no advance when en=0.
  - en rising with step high: no step.
- tick and wrap are 0 whenever adv was 0 on the previous edge.

Decomposition:
- Package led_scan_pkg:
  - mode constants MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_PINGPONG=2'b10, MODE_HOLD=2'b11.
  - dir encoding DIR_UP=1'b0, DIR_DOWN=1'b1.
- Sub-module tick_gen, parameter DIV: the prescaler counter with sync clear. Inputs clk, rst, clr; output pulse.
- Top holds the step detect, sequence/dir logic and output registers.

Test Plan:
- Use TICK_DIV=4 in all scenarios.
- Reset mid-run: rst pulse while sel=5 → a,b,c=0,0,0 and tick=wrap=0 immediately, without waiting for clk. After release, the first tick comes 4 cycles later with sel=1.
- Up mode, en=1, 40 cycles → sel sequence 0,1,…,7,0,1,… with tick every 4th cycle. wrap high only in the cycle sel becomes 0. Chained to mux_3to8, out walks 0x01→0x80→0x01.
- Down mode from reset → sel 7,6,…,0,7; wrap with the first step (0→7) and with each later 0→7.
- Ping-pong from reset → 1,2,…,7,6,…,0,1. wrap at the 7→6 and 0→1 transitions only; no repeated 7 or 0.
- Manual step, en=0, step held high 10 cycles, then two 1-cycle pulses → exactly 3 advances (sel 0→1→2→3), each 1 cycle after the rising edge. A step asserted while en=1 causes no extra advance.
- Hold and re-enable: mode=11 with en=1 → tick continues, sel frozen, wrap=0. en 1→0→1 mid-count → first tick exactly 4 cycles after en returns to 1.
